// File: rtl/ps2_keymap.sv
// ps2_keymap: PS/2 device-to-host receiver and held-key decoder.
// Raw pins are synchronized, and ps2_clk is glitch-filtered. Frames are
// sampled on filtered falling edges. Valid bytes update scan_code and a
// held-key bitmask. F0 marks a break and E0 marks an extended code.
//
// state  | meaning
// IDLE   | waiting for a start bit (data 0 on a sample event)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing the odd-parity bit
// STOP   | checking the stop bit, then committing the byte

module ps2_keymap #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err
);

    localparam int            FW       = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [FW-1:0] FLT_LOAD = FW'(FILTER_LEN - 1);
    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t          state;
    logic            clk_s1, clk_s2, dat_s1, dat_s2;
    logic            clk_filt;
    logic [FW-1:0]   filt_cnt;
    logic [TW-1:0]   tmo_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift;
    logic            parity;
    logic            brk, ext;
    logic            sample_evt;

    // A filtered falling edge occurs on the cycle the filter accepts a low level.
    assign sample_evt = clk_filt && !clk_s2 && (filt_cnt == '0);

    // Map scan codes onto keycode bit positions; unmapped codes give 0.
    function automatic logic [7:0] key_mask(input logic [7:0] code);
        logic [7:0] m;
        m = 8'h00;
        case (code)
            8'h23:   m = 8'h01;
            8'h1C:   m = 8'h02;
            8'h1D:   m = 8'h04;
            8'h1B:   m = 8'h08;
            8'h24:   m = 8'h10;
            8'h15:   m = 8'h20;
            8'h29:   m = 8'h40;
            8'h76:   m = 8'h80;
            default: m = 8'h00;
        endcase
        return m;
    endfunction

    // Two-stage synchronizers. They preset to idle-high so reset does not fake an edge.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // Glitch filter: a new level is accepted after FILTER_LEN consecutive differing cycles.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            clk_filt <= 1'b1;
            filt_cnt <= FLT_LOAD;
        end else if (clk_s2 != clk_filt) begin
            if (filt_cnt == '0) begin
                clk_filt <= clk_s2;
                filt_cnt <= FLT_LOAD;
            end else begin
                filt_cnt <= filt_cnt - FW'(1);
            end
        end else begin
            filt_cnt <= FLT_LOAD;
        end
    end

    // Frame FSM with timeout, byte commit, prefix tracking and key-state update.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            tmo_cnt    <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            parity     <= 1'b0;
            brk        <= 1'b0;
            ext        <= 1'b0;
            keycode    <= '0;
            scan_code  <= '0;
            scan_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            scan_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (state == IDLE) begin
                tmo_cnt <= '0;
                if (sample_evt && !dat_s2) begin
                    state   <= DATA;
                    bit_cnt <= '0;
                end
            end else if (sample_evt) begin
                tmo_cnt <= '0;
                case (state)
                    DATA: begin
                        shift   <= {dat_s2, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            state <= PARITY;
                    end
                    PARITY: begin
                        parity <= dat_s2;
                        state  <= STOP;
                    end
                    default: begin
                        state <= IDLE;
                        if (dat_s2 && ((^shift) ^ parity)) begin
                            scan_code  <= shift;
                            scan_valid <= 1'b1;
                            if (shift == 8'hF0) begin
                                brk <= 1'b1;
                            end else if (shift == 8'hE0) begin
                                ext <= 1'b1;
                            end else begin
                                if (!ext) begin
                                    if (brk)
                                        keycode <= keycode & ~key_mask(shift);
                                    else
                                        keycode <= keycode | key_mask(shift);
                                end
                                brk <= 1'b0;
                                ext <= 1'b0;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            brk       <= 1'b0;
                            ext       <= 1'b0;
                        end
                    end
                endcase
            end else if (tmo_cnt == TMO_LAST) begin
                // Abandon the partial byte. Prefix flags survive the timeout.
                state   <= IDLE;
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_ps2_keymap.sv
// Testbench for ps2_keymap: table of whole frames with expected key state,
// plus hand sequences for timeout, clock glitch and mid-frame reset.

module tb_ps2_keymap;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 400;
    localparam int HALF       = 20;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] keycode, scan_code;
    logic       scan_valid, frame_err;

    int n_cmp = 0;
    int n_bad = 0;
    int sv_cnt = 0;
    int fe_cnt = 0;
    logic prev_sv = 1'b0, prev_fe = 1'b0;

    ps2_keymap #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .keycode(keycode), .scan_code(scan_code),
        .scan_valid(scan_valid), .frame_err(frame_err)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [7:0] code;
        bit         bad_par;
        bit         bad_stop;
        logic [7:0] key;
        logic [7:0] scan;
        int         sv;
        int         fe;
    } vec_t;

    vec_t vecs[$];

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Count output pulses and check they are single-cycle and mutually exclusive.
    always @(negedge Clk) begin
        if (Reset_n) begin
            if (scan_valid || frame_err) begin
                n_cmp++;
                if ((scan_valid && frame_err) || (scan_valid && prev_sv) || (frame_err && prev_fe)) begin
                    n_bad++;
                    $display("FAIL pulse_shape: sv=%0b fe=%0b prev_sv=%0b prev_fe=%0b",
                             scan_valid, frame_err, prev_sv, prev_fe);
                end
            end
            if (scan_valid) sv_cnt++;
            if (frame_err)  fe_cnt++;
        end
        prev_sv = scan_valid;
        prev_fe = frame_err;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic put_bit(input logic b);
        ps2_data = b;
        wait_clk(HALF);
        ps2_clk = 1'b0;
        wait_clk(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        put_bit(1'b0);
        for (int i = 0; i < 8; i++) put_bit(b[i]);
        put_bit((~^b) ^ bad_par);
        put_bit(~bad_stop);
        ps2_data = 1'b1;
        wait_clk(2 * HALF);
    endtask

    task automatic run_frame(input string name, input logic [7:0] code, input bit bp, input bit bs,
                             input logic [7:0] ekey, input logic [7:0] escan, input int esv, input int efe);
        int sv0, fe0;
        sv0 = sv_cnt;
        fe0 = fe_cnt;
        send_frame(code, bp, bs);
        check8({name, " keycode"}, keycode, ekey);
        check8({name, " scan_code"}, scan_code, escan);
        check_int({name, " scan_valid count"}, sv_cnt - sv0, esv);
        check_int({name, " frame_err count"}, fe_cnt - fe0, efe);
    endtask

    initial begin
        int sv0, fe0;
        vecs.push_back('{8'h1D, 0, 0, 8'h04, 8'h1D, 1, 0});
        vecs.push_back('{8'hF0, 0, 0, 8'h04, 8'hF0, 1, 0});
        vecs.push_back('{8'h1D, 0, 0, 8'h00, 8'h1D, 1, 0});
        vecs.push_back('{8'h23, 0, 0, 8'h01, 8'h23, 1, 0});
        vecs.push_back('{8'h1D, 0, 0, 8'h05, 8'h1D, 1, 0});
        vecs.push_back('{8'h76, 0, 0, 8'h85, 8'h76, 1, 0});
        vecs.push_back('{8'hF0, 0, 0, 8'h85, 8'hF0, 1, 0});
        vecs.push_back('{8'h23, 0, 0, 8'h84, 8'h23, 1, 0});
        vecs.push_back('{8'h1C, 1, 0, 8'h84, 8'h23, 0, 1});
        vecs.push_back('{8'h1C, 0, 0, 8'h86, 8'h1C, 1, 0});
        vecs.push_back('{8'hF0, 0, 0, 8'h86, 8'hF0, 1, 0});
        vecs.push_back('{8'h1D, 0, 0, 8'h82, 8'h1D, 1, 0});
        vecs.push_back('{8'hE0, 0, 0, 8'h82, 8'hE0, 1, 0});
        vecs.push_back('{8'h1D, 0, 0, 8'h82, 8'h1D, 1, 0});
        vecs.push_back('{8'h1D, 0, 0, 8'h86, 8'h1D, 1, 0});
        vecs.push_back('{8'hE0, 0, 0, 8'h86, 8'hE0, 1, 0});
        vecs.push_back('{8'hF0, 0, 0, 8'h86, 8'hF0, 1, 0});
        vecs.push_back('{8'h1D, 0, 0, 8'h86, 8'h1D, 1, 0});
        vecs.push_back('{8'hF0, 0, 0, 8'h86, 8'hF0, 1, 0});
        vecs.push_back('{8'h24, 1, 0, 8'h86, 8'hF0, 0, 1});
        vecs.push_back('{8'h24, 0, 0, 8'h96, 8'h24, 1, 0});
        vecs.push_back('{8'h11, 0, 0, 8'h96, 8'h11, 1, 0});
        vecs.push_back('{8'h24, 0, 0, 8'h96, 8'h24, 1, 0});
        vecs.push_back('{8'h29, 0, 1, 8'h96, 8'h24, 0, 1});

        wait_clk(5);
        check8("reset keycode", keycode, 8'h00);
        check8("reset scan_code", scan_code, 8'h00);
        check_int("reset scan_valid", int'(scan_valid), 0);
        check_int("reset frame_err", int'(frame_err), 0);
        Reset_n = 1'b1;
        wait_clk(5);

        foreach (vecs[i])
            run_frame($sformatf("vec%0d", i), vecs[i].code, vecs[i].bad_par, vecs[i].bad_stop,
                      vecs[i].key, vecs[i].scan, vecs[i].sv, vecs[i].fe);

        // Abandon a frame after 4 data bits, then let the timeout expire.
        sv0 = sv_cnt;
        fe0 = fe_cnt;
        put_bit(1'b0);
        for (int i = 0; i < 4; i++) put_bit(i[0]);
        ps2_data = 1'b1;
        wait_clk(TIMEOUT + 100);
        check_int("timeout scan_valid count", sv_cnt - sv0, 0);
        check_int("timeout frame_err count", fe_cnt - fe0, 0);
        check8("timeout keycode", keycode, 8'h96);
        run_frame("after_timeout", 8'h15, 0, 0, 8'hB6, 8'h15, 1, 0);

        // Short low glitch on ps2_clk while data is low must not start a frame.
        sv0 = sv_cnt;
        fe0 = fe_cnt;
        ps2_data = 1'b0;
        wait_clk(2);
        ps2_clk = 1'b0;
        wait_clk(3);
        ps2_clk = 1'b1;
        wait_clk(HALF);
        ps2_data = 1'b1;
        wait_clk(HALF);
        check_int("glitch scan_valid count", sv_cnt - sv0, 0);
        check_int("glitch frame_err count", fe_cnt - fe0, 0);
        run_frame("glitch_brk", 8'hF0, 0, 0, 8'hB6, 8'hF0, 1, 0);
        run_frame("glitch_15", 8'h15, 0, 0, 8'h96, 8'h15, 1, 0);

        // Reset asserted while the 5th data bit is on the wire.
        put_bit(1'b0);
        put_bit(1'b1);
        put_bit(1'b0);
        put_bit(1'b0);
        put_bit(1'b1);
        ps2_data = 1'b0;
        wait_clk(HALF);
        ps2_clk = 1'b0;
        wait_clk(5);
        #2;
        Reset_n = 1'b0;
        #1;
        check8("async reset keycode", keycode, 8'h00);
        check8("async reset scan_code", scan_code, 8'h00);
        check_int("async reset scan_valid", int'(scan_valid), 0);
        check_int("async reset frame_err", int'(frame_err), 0);
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        wait_clk(10);
        Reset_n = 1'b1;
        wait_clk(10);
        run_frame("after_reset", 8'h29, 0, 0, 8'h40, 8'h29, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_keymap.md
# ps2_keymap

PS/2 keyboard receiver and key-state decoder that drives the 8-bit `keycode` held-key bitmask consumed by the camera/rotation controller. It deserializes 11-bit PS/2 device-to-host frames, tracks make/break (F0) and extended (E0) prefixes, and maintains one held/released bit per mapped key. It sits between the board PS/2 pins and the motion-control logic, in the system `Clk` domain.

## Interface

Parameters:
- `FILTER_LEN`, default 8: system cycles the synchronized `ps2_clk` must hold a new level before it is accepted.
- `TIMEOUT`, default 50000: system cycles without an accepted `ps2_clk` falling edge that abort a frame in progress.

Ports:
- `Clk`  input  1  system clock; all logic on its rising edge.
- `Reset_n`  input  1  asynchronous, active-low reset.
- `ps2_clk`  input  1  raw PS/2 clock pin, asynchronous, idle high.
- `ps2_data`  input  1  raw PS/2 data pin, asynchronous, idle high.
- `keycode`  output  8  held-key bitmask: bit0 D (0x23), bit1 A (0x1C), bit2 W (0x1D), bit3 S (0x1B), bit4 E (0x24), bit5 Q (0x15), bit6 Space (0x29), bit7 Esc (0x76).
- `scan_code`  output  8  last correctly framed byte.
- `scan_valid`  output  1  one-cycle pulse when `scan_code` updates.
- `frame_err`  output  1  one-cycle pulse on a parity or stop-bit error.

## Operation

- Input conditioning: `ps2_clk` and `ps2_data` each pass through a 2-FF synchronizer. The filtered clock level changes only after the synchronized `ps2_clk` differs from it for `FILTER_LEN` consecutive cycles. A falling edge of the filtered clock is a sample event; the synchronized `ps2_data` is sampled on that cycle.
- Frame format: start bit 0, 8 data bits LSB first, odd parity, stop bit 1.
- FSM states and transitions (all on sample events unless noted):
  - IDLE: data 0 -> DATA with bit counter 0. Data 1 -> stay in IDLE; the event is ignored and no error is flagged.
  - DATA: shift in one bit; after the 8th bit -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: -> IDLE. Valid only if the stop bit is 1 and the XOR of the 8 data bits and the parity bit is 1.
  - Timeout (not tied to a sample event): in DATA/PARITY/STOP, a cycle counter reaching `TIMEOUT` with no sample event -> IDLE, partial byte discarded. No `frame_err`; prefix flags are kept.
- Byte decode on a valid frame:
  - 0xF0: set `brk`.
  - 0xE0: set `ext`.
  - Any other byte, when `ext` is 0 and the byte is in the map: set the mapped bit if `brk` is 0, clear it if `brk` is 1.
  - Any other byte with `ext` set, or any unmapped byte: `keycode` is unchanged.
  - After any non-prefix byte, clear both `brk` and `ext`.
  - `scan_code` and `scan_valid` update for every valid byte, prefixes included.
- On an invalid frame: pulse `frame_err`, clear `brk` and `ext`, leave `keycode` and `scan_code` unchanged.
- Multiple bits may be set at once. Opposing keys (D+A) both set; priority belongs to the consumer.
- Repeated make codes (typematic) re-set an already-set bit, which has no effect.

## Timing

- Reset (`Reset_n` = 0, asynchronous, takes effect immediately even mid-frame):
  - `keycode` = 0x00, `scan_code` = 0x00, `scan_valid` = 0, `frame_err` = 0.
  - FSM = IDLE; `brk`, `ext`, bit counter and timeout counter cleared.
  - Filtered clock and both synchronizer stages preset to 1.
- Sample latency: 2 synchronizer cycles + `FILTER_LEN` cycles after the pin edge.
- On the cycle after the stop-bit sample event, all of the following register together: `scan_code`, the `scan_valid` pulse (or the `frame_err` pulse), the `keycode` update, and the prefix-flag update.
- `scan_valid` and `frame_err` are never high in the same cycle and never high for more than one cycle.
- Glitches on `ps2_clk` shorter than `FILTER_LEN` cycles produce no sample event.
- The timeout counter clears on every sample event and is held at 0 in IDLE.

## Test plan

- Make then break: send 0x1D -> `keycode` 0x04 and `scan_valid` pulses with `scan_code` 0x1D; then send F0, 1D -> two `scan_valid` pulses and `keycode` 0x00.
- Multiple keys: send 0x23, 0x1D, 0x76 -> `keycode` 0x85; send F0, 23 -> `keycode` 0x84.
- Parity error: send 0x1C with even parity -> `frame_err` pulses once, no `scan_valid`, `keycode` unchanged. Then send a correct 0x1C -> `keycode` bit1 set.
- Extended prefix: send E0, 1D -> `keycode` unchanged, `ext` clear afterwards. Then send 0x1D -> `keycode` bit2 set.
- Timeout and glitch:
  - Stop `ps2_clk` after 4 data bits for > `TIMEOUT` cycles -> FSM returns to IDLE, no pulse. Then a full 0x15 frame -> `keycode` bit5 set.
  - A 3-cycle low glitch on `ps2_clk` in IDLE -> no state change.
- Reset mid-frame: assert `Reset_n` = 0 with `keycode` 0x04 during the 5th data bit -> all outputs return to 0 asynchronously. After release, a full 0x29 frame -> `keycode` 0x40.
